// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage: sequential +4 fetch over a
// request/grant handshake with flush/branch redirects and a held-branch slot.
// Define PC_ALIGN_CHECK_EN to trap misaligned targets to EXC_VEC instead of
// silently clearing their low two bits.
module pc_gen #(
  parameter int unsigned             ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'('h20)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_addr_i,
  input  logic              branch_flg_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  input  logic              ifetch_gnt_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce,
  output logic              redirect_pending_o,
  output logic              misalign_o,
  output logic [ADDR_W-1:0] misalign_addr_o
);

  typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_PEND} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic              misalign_q, misalign_d;
  logic [ADDR_W-1:0] misalign_addr_q, misalign_addr_d;

  logic              adv;
  logic              load;
  logic [ADDR_W-1:0] tgt;

  assign ce                 = (state_q != ST_OFF);
  assign adv                = ce & ~stall_i[0] & ifetch_gnt_i;
  assign pc_o               = pc_q;
  assign redirect_pending_o = (state_q == ST_PEND);
  assign misalign_o         = misalign_q;
  assign misalign_addr_o    = misalign_addr_q;

  // Only the PC-stage stall bit matters; the low target bits are dropped in
  // the non-checking build.
  logic unused_bits;
  assign unused_bits = ^{stall_i[5:1], tgt[1:0]};

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d         = state_q;
    pc_d            = pc_q;
    pend_d          = pend_q;
    load            = 1'b0;
    tgt             = '0;
    misalign_d      = 1'b0;
    misalign_addr_d = misalign_addr_q;

    if (state_q == ST_OFF) begin
      state_d = ST_RUN;
    end else if (flush_i) begin
      load    = 1'b1;
      tgt     = flush_addr_i;
      state_d = ST_RUN;
    end else if (branch_flg_i && adv) begin
      load    = 1'b1;
      tgt     = branch_addr_i;
      state_d = ST_RUN;
    end else if (branch_flg_i) begin
      pend_d  = branch_addr_i;
      state_d = ST_PEND;
    end else if (state_q == ST_PEND && adv) begin
      load    = 1'b1;
      tgt     = pend_q;
      state_d = ST_RUN;
    end else if (adv) begin
      pc_d = pc_q + ADDR_W'(4);
    end

    if (load) begin
`ifdef PC_ALIGN_CHECK_EN
      if (tgt[1:0] != 2'b00) begin
        pc_d            = EXC_VEC;
        misalign_d      = 1'b1;
        misalign_addr_d = tgt;
      end else begin
        pc_d = tgt;
      end
`else
      pc_d = {tgt[ADDR_W-1:2], 2'b00};
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_OFF;
      pc_q            <= RESET_VEC;
      pend_q          <= '0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      pend_q          <= pend_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed redirect/stall/wrap/alignment
// vectors, a per-cycle reference model, and hand-computed spot checks.
module tb_pc_gen;

  localparam int unsigned ADDR_W    = 32;
  localparam logic [31:0] RESET_VEC = 32'h0;
  localparam logic [31:0] EXC_VEC   = 32'h20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_addr_i = '0;
  logic        branch_flg_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        ifetch_gnt_i = 1'b1;
  logic [31:0] pc_o;
  logic        ce;
  logic        redirect_pending_o;
  logic        misalign_o;
  logic [31:0] misalign_addr_o;

  pc_gen #(.ADDR_W(ADDR_W), .RESET_VEC(RESET_VEC), .EXC_VEC(EXC_VEC)) dut (
    .clk                (clk),
    .rst                (rst),
    .stall_i            (stall_i),
    .flush_i            (flush_i),
    .flush_addr_i       (flush_addr_i),
    .branch_flg_i       (branch_flg_i),
    .branch_addr_i      (branch_addr_i),
    .ifetch_gnt_i       (ifetch_gnt_i),
    .pc_o               (pc_o),
    .ce                 (ce),
    .redirect_pending_o (redirect_pending_o),
    .misalign_o         (misalign_o),
    .misalign_addr_o    (misalign_addr_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the fetch unit must present, from the redirect rules.
  bit          m_on;
  bit          m_pend;
  logic [31:0] m_pend_addr;
  logic [31:0] m_pc;
  bit          m_mis;
  logic [31:0] m_mis_addr;

  function automatic void m_apply(input logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
    if (t % 4 != 0) begin
      m_pc       = EXC_VEC;
      m_mis      = 1'b1;
      m_mis_addr = t;
    end else begin
      m_pc = t;
    end
`else
    m_pc = t & ~32'h3;
`endif
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_on = 0; m_pend = 0; m_pend_addr = '0; m_pc = RESET_VEC; m_mis = 0; m_mis_addr = '0;
    end else begin
      bit can_adv;
      m_mis   = 0;
      can_adv = m_on && !stall_i[0] && ifetch_gnt_i;
      if (!m_on) begin
        m_on = 1;
      end else if (flush_i) begin
        m_pend = 0;
        m_apply(flush_addr_i);
      end else if (branch_flg_i) begin
        if (can_adv) begin
          m_pend = 0;
          m_apply(branch_addr_i);
        end else begin
          m_pend      = 1;
          m_pend_addr = branch_addr_i;
        end
      end else if (can_adv) begin
        if (m_pend) begin
          m_pend = 0;
          m_apply(m_pend_addr);
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("model_pc", pc_o, m_pc);
    check("model_ce", {31'b0, ce}, {31'b0, m_on});
    check("model_pending", {31'b0, redirect_pending_o}, {31'b0, m_pend});
    check("model_misalign", {31'b0, misalign_o}, {31'b0, m_mis});
    check("model_misalign_addr", misalign_addr_o, m_mis_addr);
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset held for 3 cycles.
    cyc(3);
    check("rst_pc", pc_o, RESET_VEC);
    check("rst_ce", {31'b0, ce}, 32'd0);
    check("rst_pending", {31'b0, redirect_pending_o}, 32'd0);
    rst = 1'b1;
    cyc();
    check("first_ce", {31'b0, ce}, 32'd1);
    check("first_pc", pc_o, 32'h0);
    cyc();
    check("seq_pc4", pc_o, 32'h4);
    cyc();
    check("seq_pc8", pc_o, 32'h8);
    cyc(2);
    check("seq_pc10", pc_o, 32'h10);

    // Grant backpressure.
    ifetch_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("gnt_hold", pc_o, 32'h10);
    end
    ifetch_gnt_i = 1'b1;
    cyc();
    check("gnt_resume", pc_o, 32'h14);

    // Branch under stall is held until the stall releases.
    stall_i       = 6'b000001;
    branch_flg_i  = 1'b1;
    branch_addr_i = 32'h200;
    cyc();
    branch_flg_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("held_pending", {31'b0, redirect_pending_o}, 32'd1);
      check("held_pc", pc_o, 32'h14);
      if (i < 3) cyc();
    end
    stall_i = '0;
    cyc();
    check("held_apply", pc_o, 32'h200);
    check("held_cleared", {31'b0, redirect_pending_o}, 32'd0);
    cyc();
    check("held_next", pc_o, 32'h204);

    // Flush beats a same-cycle branch and a held target.
    stall_i       = 6'b000001;
    branch_flg_i  = 1'b1;
    branch_addr_i = 32'h400;
    cyc();
    check("prio_pending", {31'b0, redirect_pending_o}, 32'd1);
    flush_i       = 1'b1;
    flush_addr_i  = 32'h80;
    branch_addr_i = 32'h300;
    cyc();
    flush_i      = 1'b0;
    branch_flg_i = 1'b0;
    stall_i      = '0;
    check("prio_flush_pc", pc_o, 32'h80);
    check("prio_cleared", {31'b0, redirect_pending_o}, 32'd0);
    cyc();
    check("prio_next", pc_o, 32'h84);
    cyc();
    check("prio_next2", pc_o, 32'h88);

    // Flush changes the address even without a grant.
    ifetch_gnt_i = 1'b0;
    flush_i      = 1'b1;
    flush_addr_i = 32'h40;
    cyc();
    flush_i = 1'b0;
    check("flush_nognt", pc_o, 32'h40);
    cyc();
    check("flush_nognt_hold", pc_o, 32'h40);
    ifetch_gnt_i = 1'b1;

    // Address wrap.
    branch_flg_i  = 1'b1;
    branch_addr_i = 32'hFFFF_FFFC;
    cyc();
    branch_flg_i = 1'b0;
    check("wrap_top", pc_o, 32'hFFFF_FFFC);
    cyc();
    check("wrap_zero", pc_o, 32'h0);

    // Misaligned branch target.
    branch_flg_i  = 1'b1;
    branch_addr_i = 32'h102;
    cyc();
    branch_flg_i = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    check("mis_pc", pc_o, EXC_VEC);
    check("mis_pulse", {31'b0, misalign_o}, 32'd1);
    check("mis_addr", misalign_addr_o, 32'h102);
    cyc();
    check("mis_pulse_end", {31'b0, misalign_o}, 32'd0);
    check("mis_after", pc_o, EXC_VEC + 32'd4);
`else
    check("mis_pc", pc_o, 32'h100);
    check("mis_pulse", {31'b0, misalign_o}, 32'd0);
    cyc();
    check("mis_after", pc_o, 32'h104);
`endif

    // Reset while a branch is held: target is lost.
    stall_i       = 6'b000001;
    branch_flg_i  = 1'b1;
    branch_addr_i = 32'h500;
    cyc();
    branch_flg_i = 1'b0;
    check("rst_pend_before", {31'b0, redirect_pending_o}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_async_pc", pc_o, RESET_VEC);
    check("rst_async_ce", {31'b0, ce}, 32'd0);
    check("rst_async_pending", {31'b0, redirect_pending_o}, 32'd0);
    cyc();
    rst     = 1'b1;
    stall_i = '0;
    cyc();
    check("rerun_pc", pc_o, RESET_VEC);
    cyc();
    check("rerun_pc4", pc_o, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
